// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and sizing helpers for the UART transmit feeder.
package uart_tx_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Smallest r with 2**r >= n; used for pointer, count and wait-counter widths.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = log2_ceil(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered transmit front-end: host words queue in a FIFO and are handed to the
// UART transceiver one at a time, paced by the transceiver's busy flag.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int TX_WORD_LENGTH   = 8,
  parameter int TX_NO_OF_WORDS   = 1,
  parameter int FIFO_DEPTH       = 16,
  parameter int BUSY_WAIT_CYCLES = 4,
  localparam int W  = TX_WORD_LENGTH * TX_NO_OF_WORDS,
  localparam int CW = log2_ceil(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  wr_data_in,
  input  logic          wr_enable_in,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [CW-1:0] fifo_count,
  output logic          overflow_error,
  output logic          timeout_error,
  input  logic          clear_errors_in,
  output logic [W-1:0]  tx_parallel_data_out,
  output logic          tx_data_wr_enable_out,
  input  logic          tx_busy_in,
  output state_t        fsm_state
);

  localparam int WW = log2_ceil(BUSY_WAIT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(BUSY_WAIT_CYCLES - 1);

  logic          pop;
  logic          overflow_evt;
  logic [W-1:0]  head;
  logic [WW-1:0] wait_cnt;

  // Handshake: tx_data_wr_enable_out is a one-cycle load strobe with data held
  // on tx_parallel_data_out; the transceiver acknowledges by raising tx_busy_in
  // and signals completion by dropping it. A new load starts only when busy is low.
  assign pop          = (fsm_state == IDLE) && !fifo_empty && !tx_busy_in;
  assign overflow_evt = wr_enable_in && fifo_full && !pop;

  uart_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_enable_in),
    .pop     (pop),
    .wr_data (wr_data_in),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_state             <= IDLE;
      wait_cnt              <= '0;
      tx_parallel_data_out  <= '0;
      tx_data_wr_enable_out <= 1'b0;
      timeout_error         <= 1'b0;
    end else begin
      tx_data_wr_enable_out <= 1'b0;
      if (clear_errors_in) timeout_error <= 1'b0;
      case (fsm_state)
        IDLE: begin
          if (pop) begin
            tx_parallel_data_out  <= head;
            tx_data_wr_enable_out <= 1'b1;
            fsm_state             <= LOAD;
          end
        end
        LOAD: begin
          wait_cnt  <= '0;
          fsm_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy_in) begin
            fsm_state <= WAIT_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_error <= 1'b1;
            fsm_state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_in) fsm_state <= IDLE;
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_error <= 1'b0;
    end else if (overflow_evt) begin
      overflow_error <= 1'b1;
    end else if (clear_errors_in) begin
      overflow_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: latency, ordering, overflow, timeout and reset.
module tb_uart_tx_feeder;
  import uart_tx_feeder_pkg::*;

  localparam int W  = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  wr_data_in = '0;
  logic          wr_enable_in = 1'b0;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow_error;
  logic          timeout_error;
  logic          clear_errors_in = 1'b0;
  logic [W-1:0]  tx_parallel_data_out;
  logic          tx_data_wr_enable_out;
  logic          tx_busy_in = 1'b0;
  state_t        fsm_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulse_cnt    = 0;
  logic [W-1:0] exp_q[$];

  uart_tx_feeder #(
    .TX_WORD_LENGTH   (8),
    .TX_NO_OF_WORDS   (1),
    .FIFO_DEPTH       (16),
    .BUSY_WAIT_CYCLES (4)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .wr_data_in            (wr_data_in),
    .wr_enable_in          (wr_enable_in),
    .fifo_full             (fifo_full),
    .fifo_empty            (fifo_empty),
    .fifo_count            (fifo_count),
    .overflow_error        (overflow_error),
    .timeout_error         (timeout_error),
    .clear_errors_in       (clear_errors_in),
    .tx_parallel_data_out  (tx_parallel_data_out),
    .tx_data_wr_enable_out (tx_data_wr_enable_out),
    .tx_busy_in            (tx_busy_in),
    .fsm_state             (fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    wr_data_in   = d;
    wr_enable_in = 1'b1;
    step();
    wr_enable_in = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    int n;
    n = 0;
    while (!tx_data_wr_enable_out && n < 50) begin
      step();
      n++;
    end
    check(tag, 32'(tx_data_wr_enable_out), 32'd1);
  endtask

  // Transceiver model, entered in the LOAD cycle: busy rises the next cycle.
  task automatic serve(input int busy_len);
    step();
    tx_busy_in = 1'b1;
    repeat (busy_len) step();
    tx_busy_in = 1'b0;
  endtask

  // scoreboard on every load strobe
  always @(negedge clk) begin
    if (reset && tx_data_wr_enable_out) begin
      pulse_cnt++;
      check("pulse_while_busy", 32'(tx_busy_in), 32'd0);
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("pulse_data", 32'(tx_parallel_data_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // reset state
    step();
    step();
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_ovf", 32'(overflow_error), 32'd0);
    check("rst_to", 32'(timeout_error), 32'd0);
    check("rst_data", 32'(tx_parallel_data_out), 32'd0);
    check("rst_wren", 32'(tx_data_wr_enable_out), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b1;
    step();

    // single word: written at N, pulse at N+2
    exp_q.push_back(8'hA5);
    write_word(8'hA5);
    check("sw_count_n1", 32'(fifo_count), 32'd1);
    check("sw_wren_n1", 32'(tx_data_wr_enable_out), 32'd0);
    step();
    check("sw_wren_n2", 32'(tx_data_wr_enable_out), 32'd1);
    check("sw_data_n2", 32'(tx_parallel_data_out), 32'hA5);
    check("sw_state_n2", 32'(fsm_state), 32'(LOAD));
    check("sw_count_n2", 32'(fifo_count), 32'd0);
    serve(10);
    check("sw_state_busy", 32'(fsm_state), 32'(WAIT_DONE));
    step();
    check("sw_state_idle", 32'(fsm_state), 32'(IDLE));
    check("sw_pulses", 32'(pulse_cnt), 32'd1);
    check("sw_hold_data", 32'(tx_parallel_data_out), 32'hA5);

    // burst fill while transceiver busy, then drain in order
    tx_busy_in = 1'b1;
    for (int i = 0; i < 16; i++) write_word(W'(i));
    check("burst_full", 32'(fifo_full), 32'd1);
    check("burst_count", 32'(fifo_count), 32'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(W'(i));
    tx_busy_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_pulse("burst_pulse");
      serve(3);
    end
    step();
    step();
    check("burst_empty", 32'(fifo_empty), 32'd1);
    check("burst_count0", 32'(fifo_count), 32'd0);
    check("burst_pulses", 32'(pulse_cnt), 32'd17);

    // overflow, set-wins-over-clear, then clear
    tx_busy_in = 1'b1;
    for (int i = 0; i < 16; i++) write_word(W'(8'h10 + i));
    check("ovf_pre", 32'(overflow_error), 32'd0);
    write_word(8'hEE);
    check("ovf_set", 32'(overflow_error), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd16);
    clear_errors_in = 1'b1;
    write_word(8'hEF);
    clear_errors_in = 1'b0;
    check("ovf_set_wins", 32'(overflow_error), 32'd1);
    clear_errors_in = 1'b1;
    step();
    clear_errors_in = 1'b0;
    check("ovf_cleared", 32'(overflow_error), 32'd0);

    // push on the pop cycle while full
    for (int i = 0; i < 16; i++) exp_q.push_back(W'(8'h10 + i));
    exp_q.push_back(8'h20);
    tx_busy_in = 1'b0;
    write_word(8'h20);
    check("pp_count", 32'(fifo_count), 32'd16);
    check("pp_full", 32'(fifo_full), 32'd1);
    check("pp_ovf", 32'(overflow_error), 32'd0);
    check("pp_wren", 32'(tx_data_wr_enable_out), 32'd1);
    serve(3);
    for (int i = 0; i < 16; i++) begin
      wait_pulse("pp_pulse");
      serve(3);
    end
    step();
    step();
    check("pp_empty", 32'(fifo_empty), 32'd1);
    check("pp_pulses", 32'(pulse_cnt), 32'd34);

    // timeout: busy never rises
    exp_q.push_back(8'h55);
    write_word(8'h55);
    wait_pulse("to_pulse");
    repeat (4) step();
    check("to_not_yet", 32'(timeout_error), 32'd0);
    check("to_state_wait", 32'(fsm_state), 32'(WAIT_BUSY));
    step();
    check("to_set", 32'(timeout_error), 32'd1);
    check("to_state_idle", 32'(fsm_state), 32'(IDLE));
    exp_q.push_back(8'h66);
    write_word(8'h66);
    wait_pulse("to_next_pulse");
    serve(2);
    step();
    check("to_sticky", 32'(timeout_error), 32'd1);
    clear_errors_in = 1'b1;
    step();
    clear_errors_in = 1'b0;
    check("to_cleared", 32'(timeout_error), 32'd0);

    // reset during WAIT_DONE with 5 words queued
    tx_busy_in = 1'b1;
    for (int i = 0; i < 6; i++) write_word(W'(8'h30 + i));
    exp_q.push_back(8'h30);
    tx_busy_in = 1'b0;
    step();
    check("mr_load", 32'(tx_data_wr_enable_out), 32'd1);
    step();
    tx_busy_in = 1'b1;
    step();
    check("mr_state", 32'(fsm_state), 32'(WAIT_DONE));
    check("mr_count5", 32'(fifo_count), 32'd5);
    #1;
    reset = 1'b0;
    #1;
    check("mr_count0", 32'(fifo_count), 32'd0);
    check("mr_empty", 32'(fifo_empty), 32'd1);
    check("mr_data0", 32'(tx_parallel_data_out), 32'd0);
    check("mr_state0", 32'(fsm_state), 32'(IDLE));
    step();
    step();
    reset = 1'b1;
    write_word(8'h77);
    repeat (4) step();
    check("mr_hold_state", 32'(fsm_state), 32'(IDLE));
    check("mr_hold_count", 32'(fifo_count), 32'd1);
    check("mr_hold_pulses", 32'(pulse_cnt), 32'd37);
    exp_q.push_back(8'h77);
    tx_busy_in = 1'b0;
    wait_pulse("mr_pulse");
    serve(2);
    step();
    step();
    check("end_pulses", 32'(pulse_cnt), 32'd38);
    check("end_queue", 32'(exp_q.size()), 32'd0);
    check("end_empty", 32'(fifo_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffered front-end for one UART transceiver's transmit side; sits directly upstream of the transceiver's tx_parallel_data_in / tx_data_wr_enable_in / tx_busy_out interface.
- Accepts words from a host at full clock rate into a synchronous FIFO.
- Drains one word at a time into the transceiver, pacing itself on the transceiver's busy flag.
- Flags overflow and handoff-timeout errors.

Parameters:
- TX_WORD_LENGTH, 8: UART data bits per word (6, 7 or 8); must match the transceiver.
- TX_NO_OF_WORDS, 1: words per transceiver load; W = TX_WORD_LENGTH*TX_NO_OF_WORDS.
- FIFO_DEPTH, 16: FIFO entries of W bits; power of 2, at least 2.
- BUSY_WAIT_CYCLES, 4: cycles allowed for tx_busy_in to rise after a load pulse; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_data_in  in  W  host write data.
- wr_enable_in  in  1  host write strobe, one word per cycle high.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_empty  out  1  FIFO holds 0 words.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow_error  out  1  sticky; a write was dropped.
- timeout_error  out  1  sticky; busy never rose after a load.
- clear_errors_in  in  1  synchronous clear of both sticky flags.
- tx_parallel_data_out  out  W  to transceiver tx_parallel_data_in.
- tx_data_wr_enable_out  out  1  to transceiver tx_data_wr_enable_in; one-cycle pulse.
- tx_busy_in  in  1  from transceiver tx_busy_out.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, count 0, fifo_empty=1, fifo_full=0, both errors 0, tx_parallel_data_out=0, tx_data_wr_enable_out=0, FSM=IDLE. All outputs are registered.
- FIFO write: accepted when wr_enable_in=1 and (not full, or a pop occurs in the same cycle). Count, full and empty update in the following cycle.
- Write while full with no pop: data dropped, count unchanged, overflow_error=1 from the next cycle.
- Simultaneous push and pop: count unchanged; data order preserved. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE: if fifo_empty=0 and tx_busy_in=0, pop the head word into tx_parallel_data_out and go to LOAD. Otherwise stay.
- LOAD: tx_data_wr_enable_out=1 for exactly this cycle; clear the wait counter; go to WAIT_BUSY.
- WAIT_BUSY: if tx_busy_in=1, go to WAIT_DONE. Otherwise increment the counter; after BUSY_WAIT_CYCLES cycles without busy, set timeout_error and go to IDLE.
- WAIT_DONE: when tx_busy_in=0, go to IDLE.
- Latency: a word written at cycle N into an empty FIFO, with an idle transceiver, is popped at N+1 and pulsed at N+2. Back-to-back words are spaced by at least the transceiver busy time plus 3 cycles.
- tx_parallel_data_out is held stable from LOAD until the next pop.
- clear_errors_in: clears both flags next cycle. If an error event coincides with the clear, the set wins.
- Reset mid-transfer: everything returns to reset values and buffered words are lost. After release, IDLE will not load while tx_busy_in is still 1.

Decomposition:
- Shared package uart_tx_feeder_pkg: FSM state encodings (IDLE=0, LOAD=1, WAIT_BUSY=2, WAIT_DONE=3) and a log2 width function for pointer and count sizing.
- One sub-module, uart_sync_fifo (parameters WIDTH, DEPTH): single clock; push/pop; full, empty and count outputs; same reset.
- FSM, wait counter and error flags live in uart_tx_feeder.

Test Plan:
- Single word: write 8'hA5 at cycle N, tx_busy_in=0 -> tx_data_wr_enable_out pulses at N+2 with data 8'hA5. Model busy high for 10 cycles -> no further pulse, FSM back to IDLE.
- Burst and order: write 16 words 0x00..0x0F back-to-back -> fifo_full=1, count=16. Transceiver model drains them -> pulses carry 0x00..0x0F in order, each pulse only after busy falls; fifo_empty=1 at the end.
- Overflow: fill to 16, write 0xEE while no pop -> overflow_error=1, count stays 16, 0xEE never transmitted. clear_errors_in -> flag 0 next cycle.
- Simultaneous push/pop when full: write on the pop cycle -> accepted, count stays 16, no overflow.
- Timeout: busy model never rises -> timeout_error=1 exactly BUSY_WAIT_CYCLES+1 cycles after the pulse. Next word loads from IDLE.
- Reset mid-transfer: assert reset during WAIT_DONE with 5 words queued -> immediate count=0 and all outputs 0. Hold tx_busy_in=1 after release -> no load until it falls.
